// File: rtl/echo_serializador.sv
// -----------------------------------------------------------------------------
// echo_serializador
//
// Serial transmitter that sits behind the 5-bit echo encoder. A code word
// S1..S5 offered with valid is sent on a single line as an 8-bit frame:
//   start (0), S1, S2, S3, S4, S5, even parity, stop (1)
// Every bit is held for BIT_TICKS clock cycles. A one-entry holding buffer
// accepts a second word while a frame is on the line. A third word offered
// while the buffer is occupied is dropped, and overrun pulses.
//
// Parameters
//   BIT_TICKS : clock cycles per transmitted bit (1..255)
//
// Ports
//   clk      in   clock; every state change happens on the rising edge
//   rst_n    in   asynchronous active-low reset
//   valid    in   a code word is present on s1..s5 this edge
//   s1..s5   in   code word bits, s1 is sent first
//   tx       out  serial line, idles high
//   busy     out  a frame is on the line
//   full     out  the holding buffer holds a word
//   done     out  one-cycle pulse after each completed frame
//   overrun  out  one-cycle pulse after an offered word was dropped
//
// All outputs come straight from flops. tx is registered from the next-state
// decode, so the line already shows the start bit in the cycle that follows
// the edge that accepted the word.
// -----------------------------------------------------------------------------
module echo_serializador #(
  parameter int BIT_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic s1,
  input  logic s2,
  input  logic s3,
  input  logic s4,
  input  logic s5,
  output logic tx,
  output logic busy,
  output logic full,
  output logic done,
  output logic overrun
);

  // Tick counter width is ceil(log2(BIT_TICKS)), but never narrower than one
  // bit so that BIT_TICKS = 1 still elaborates.
  localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [4:0]      shift_reg;
  logic [4:0]      shift_nxt;
  logic [4:0]      buf_reg;
  logic [4:0]      buf_nxt;
  logic            full_nxt;
  logic [TW-1:0]   tick_cnt;
  logic [TW-1:0]   tick_nxt;
  logic [2:0]      idx;
  logic [2:0]      idx_nxt;
  logic            parity;
  logic            parity_nxt;
  logic            tx_nxt;
  logic            done_nxt;
  logic            overrun_nxt;
  logic [4:0]      in_word;
  logic            tick_last;
  logic            frame_end;

  // Bit 0 of every word register holds S1, so shifting right walks the word
  // out in S1..S5 order.
  assign in_word   = {s5, s4, s3, s2, s1};
  assign tick_last = (tick_cnt == TICK_LAST);

  // The frame-end edge is the edge that closes the last stop cycle. Buffer
  // capture and overrun are decided differently on this edge, because the
  // buffer is being drained at the same moment.
  assign frame_end = (state == STOP) && tick_last;

  // Next-state and next-output decode.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    buf_nxt     = buf_reg;
    full_nxt    = full;
    tick_nxt    = tick_cnt;
    idx_nxt     = idx;
    parity_nxt  = parity;
    done_nxt    = 1'b0;
    overrun_nxt = 1'b0;
    tx_nxt      = 1'b1;

    // The tick counter free-runs modulo BIT_TICKS whenever a frame is active
    // and restarts at zero whenever a new frame is loaded.
    if (state != IDLE) begin
      if (tick_last) begin
        tick_nxt = '0;
      end else begin
        tick_nxt = tick_cnt + 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (valid) begin
          state_nxt  = START;
          shift_nxt  = in_word;
          parity_nxt = ^in_word;
          tick_nxt   = '0;
          idx_nxt    = '0;
        end
      end

      START: begin
        if (tick_last) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end
      end

      DATA: begin
        if (tick_last) begin
          if (idx == 3'd4) begin
            state_nxt = PARITY;
          end else begin
            shift_nxt = shift_reg >> 1;
            idx_nxt   = idx + 3'd1;
          end
        end
      end

      PARITY: begin
        if (tick_last) begin
          state_nxt = STOP;
        end
      end

      STOP: begin
        if (tick_last) begin
          done_nxt = 1'b1;
          if (full) begin
            // Drain the buffer. A word offered on this same edge refills it,
            // so this collision never counts as an overrun.
            state_nxt  = START;
            shift_nxt  = buf_reg;
            parity_nxt = ^buf_reg;
            idx_nxt    = '0;
            full_nxt   = valid;
            if (valid) begin
              buf_nxt = in_word;
            end
          end else if (valid) begin
            state_nxt  = START;
            shift_nxt  = in_word;
            parity_nxt = ^in_word;
            idx_nxt    = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Words offered mid-frame go to the holding buffer, or are dropped when
    // it is already occupied.
    if ((state != IDLE) && !frame_end && valid) begin
      if (!full) begin
        buf_nxt  = in_word;
        full_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end

    // The line value for the cycle after this edge follows the state being
    // entered.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = parity_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  // State and output registers. Reset takes effect immediately, including
  // mid-frame, and throws away any buffered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      buf_reg   <= '0;
      full      <= 1'b0;
      tick_cnt  <= '0;
      idx       <= '0;
      parity    <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      buf_reg   <= buf_nxt;
      full      <= full_nxt;
      tick_cnt  <= tick_nxt;
      idx       <= idx_nxt;
      parity    <= parity_nxt;
      tx        <= tx_nxt;
      busy      <= (state_nxt != IDLE);
      done      <= done_nxt;
      overrun   <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_echo_serializador.sv
// -----------------------------------------------------------------------------
// tb_echo_serializador
//
// Directed bench for echo_serializador. Two instances share the inputs: dut0
// uses BIT_TICKS = 4 and dut1 uses BIT_TICKS = 1. Each scenario schedules
// valid pulses against a cycle index, captures {tx,busy,full,done,overrun}
// after every rising edge, and compares that capture with a hand-built
// expected trace. Cycle index c means "sampled after rising edge c", where
// edge 0 is the first edge of the scenario.
// -----------------------------------------------------------------------------
module tb_echo_serializador;

  localparam int BT   = 4;
  localparam int MAXC = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, s4 = 1'b0, s5 = 1'b0;

  logic tx0, busy0, full0, done0, ovr0;
  logic tx1, busy1, full1, done1, ovr1;

  int n_checks = 0;
  int n_fail   = 0;

  logic       sched_valid [MAXC];
  logic [4:0] sched_word  [MAXC];
  logic [4:0] cap0        [MAXC];
  logic [4:0] cap1        [MAXC];
  logic [4:0] expv        [MAXC];

  // Words are written with bit 0 = S1. "10110" as S1..S5 is 5'b01101.
  localparam logic [4:0] W_A = 5'b01101;
  localparam logic [4:0] W_B = 5'b10010;
  localparam logic [4:0] W_C = 5'b00111;

  echo_serializador #(.BIT_TICKS(BT)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid(valid),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5),
    .tx(tx0), .busy(busy0), .full(full0), .done(done0), .overrun(ovr0)
  );

  echo_serializador #(.BIT_TICKS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid(valid),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5),
    .tx(tx1), .busy(busy1), .full(full1), .done(done1), .overrun(ovr1)
  );

  always #5 clk = ~clk;

  // Stimulus scheduling.
  task automatic clear_sched();
    for (int c = 0; c < MAXC; c++) begin
      sched_valid[c] = 1'b0;
      sched_word[c]  = 5'b0;
    end
  endtask

  task automatic schedule(input int c, input logic [4:0] w);
    sched_valid[c] = 1'b1;
    sched_word[c]  = w;
  endtask

  // Drives the schedule from a falling edge and samples both DUTs on the
  // falling edge after each rising edge. Called and returns at a falling edge.
  task automatic apply_stimulus(input int n);
    for (int c = 0; c < n; c++) begin
      valid = sched_valid[c];
      {s5, s4, s3, s2, s1} = sched_word[c];
      @(posedge clk);
      @(negedge clk);
      cap0[c] = {tx0, busy0, full0, done0, ovr0};
      cap1[c] = {tx1, busy1, full1, done1, ovr1};
    end
    valid = 1'b0;
  endtask

  // Expected-trace construction: idle line everywhere, then frames, buffer
  // occupancy and overrun pulses added at hand-chosen cycles.
  task automatic clear_expect();
    for (int c = 0; c < MAXC; c++) expv[c] = 5'b10000;
  endtask

  function automatic logic frame_bit(input logic [4:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= 5) return w[b-1];
    if (b == 6) return ^w;
    return 1'b1;
  endfunction

  task automatic expect_frame(input int start, input logic [4:0] w, input int bt);
    for (int c = start; c < start + 8*bt; c++) begin
      expv[c][4] = frame_bit(w, (c - start) / bt);
      expv[c][3] = 1'b1;
    end
    expv[start + 8*bt][1] = 1'b1;
  endtask

  task automatic expect_full(input int first, input int last_excl);
    for (int c = first; c < last_excl; c++) expv[c][2] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tx0, busy0, full0, done0, ovr0} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL reset_dut0 {tx,busy,full,done,overrun} got %b expected 10000",
               {tx0, busy0, full0, done0, ovr0});
    end
    n_checks++;
    if ({tx1, busy1, full1, done1, ovr1} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL reset_dut1 {tx,busy,full,done,overrun} got %b expected 10000",
               {tx1, busy1, full1, done1, ovr1});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [7:0] seq;
    // S1..S5 = 1,0,1,1,0 -> line 0,1,0,1,1,0,1,1 (bit 0 sent first)
    seq = 8'b11011010;
    clear_sched();
    schedule(0, W_A);
    apply_stimulus(36);
    clear_expect();
    expect_frame(0, W_A, BT);
    for (int c = 0; c < 36; c++) begin
      n_checks++;
      if (cap0[c] !== expv[c]) begin
        n_fail++;
        $display("[TB] FAIL single_frame cycle %0d {tx,busy,full,done,overrun} got %b expected %b",
                 c, cap0[c], expv[c]);
      end
    end
    for (int b = 0; b < 8; b++) begin
      n_checks++;
      if (cap0[4*b + 2][4] !== seq[b]) begin
        n_fail++;
        $display("[TB] FAIL single_frame_bit %0d tx got %b expected %b", b, cap0[4*b + 2][4], seq[b]);
      end
    end
  endtask

  task automatic test_parity();
    logic [4:0] words [2];
    logic       par   [2];
    words[0] = 5'b00000; par[0] = 1'b0;
    words[1] = 5'b11111; par[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clear_sched();
      schedule(0, words[i]);
      apply_stimulus(36);
      clear_expect();
      expect_frame(0, words[i], BT);
      n_checks++;
      if (cap0[25][4] !== par[i]) begin
        n_fail++;
        $display("[TB] FAIL parity_bit word %b tx got %b expected %b", words[i], cap0[25][4], par[i]);
      end
      for (int c = 0; c < 36; c++) begin
        n_checks++;
        if (cap0[c] !== expv[c]) begin
          n_fail++;
          $display("[TB] FAIL parity_frame word %b cycle %0d got %b expected %b",
                   words[i], c, cap0[c], expv[c]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_sched();
    schedule(0, W_A);
    schedule(3, W_B);
    apply_stimulus(68);
    clear_expect();
    expect_frame(0, W_A, BT);
    expect_frame(32, W_B, BT);
    expect_full(3, 32);
    for (int c = 0; c < 68; c++) begin
      n_checks++;
      if (cap0[c] !== expv[c]) begin
        n_fail++;
        $display("[TB] FAIL back_to_back cycle %0d {tx,busy,full,done,overrun} got %b expected %b",
                 c, cap0[c], expv[c]);
      end
    end
  endtask

  task automatic test_overrun();
    clear_sched();
    schedule(0, W_A);
    schedule(3, W_B);
    schedule(6, W_C);
    apply_stimulus(68);
    clear_expect();
    expect_frame(0, W_A, BT);
    expect_frame(32, W_B, BT);
    expect_full(3, 32);
    expv[6][0] = 1'b1;
    for (int c = 0; c < 68; c++) begin
      n_checks++;
      if (cap0[c] !== expv[c]) begin
        n_fail++;
        $display("[TB] FAIL overrun cycle %0d {tx,busy,full,done,overrun} got %b expected %b",
                 c, cap0[c], expv[c]);
      end
    end
  endtask

  task automatic test_frame_end_collision();
    clear_sched();
    schedule(0, W_A);
    schedule(3, W_B);
    schedule(32, W_C);
    apply_stimulus(100);
    clear_expect();
    expect_frame(0, W_A, BT);
    expect_frame(32, W_B, BT);
    expect_frame(64, W_C, BT);
    expect_full(3, 64);
    for (int c = 0; c < 100; c++) begin
      n_checks++;
      if (cap0[c] !== expv[c]) begin
        n_fail++;
        $display("[TB] FAIL collision cycle %0d {tx,busy,full,done,overrun} got %b expected %b",
                 c, cap0[c], expv[c]);
      end
    end
  endtask

  task automatic test_bit_ticks_one();
    clear_sched();
    schedule(0, W_A);
    schedule(2, W_B);
    schedule(8, W_C);
    apply_stimulus(70);
    // dut1: 8-cycle frames, C lands on the frame-end edge of A
    clear_expect();
    expect_frame(0, W_A, 1);
    expect_frame(8, W_B, 1);
    expect_frame(16, W_C, 1);
    expect_full(2, 16);
    for (int c = 0; c < 70; c++) begin
      n_checks++;
      if (cap1[c] !== expv[c]) begin
        n_fail++;
        $display("[TB] FAIL bit_ticks_one cycle %0d {tx,busy,full,done,overrun} got %b expected %b",
                 c, cap1[c], expv[c]);
      end
    end
    // dut0 saw the same words: C arrives mid-frame with the buffer full
    clear_expect();
    expect_frame(0, W_A, BT);
    expect_frame(32, W_B, BT);
    expect_full(2, 32);
    expv[8][0] = 1'b1;
    for (int c = 0; c < 70; c++) begin
      n_checks++;
      if (cap0[c] !== expv[c]) begin
        n_fail++;
        $display("[TB] FAIL bit_ticks_four_overrun cycle %0d got %b expected %b",
                 c, cap0[c], expv[c]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_sched();
    schedule(0, W_A);
    schedule(3, W_B);
    apply_stimulus(14);
    clear_expect();
    expect_frame(0, W_A, BT);
    expect_full(3, 14);
    for (int c = 0; c < 14; c++) begin
      n_checks++;
      if (cap0[c] !== expv[c]) begin
        n_fail++;
        $display("[TB] FAIL pre_reset cycle %0d got %b expected %b", c, cap0[c], expv[c]);
      end
    end
    // cycle 13 is inside the S3 bit; reset must act without a clock edge
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx0, busy0, full0, done0, ovr0} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL async_reset {tx,busy,full,done,overrun} got %b expected 10000",
               {tx0, busy0, full0, done0, ovr0});
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({tx0, busy0, full0, done0, ovr0} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL held_reset {tx,busy,full,done,overrun} got %b expected 10000",
               {tx0, busy0, full0, done0, ovr0});
    end
    rst_n = 1'b1;
    // the buffered word must be gone: only the new frame goes out
    clear_sched();
    schedule(0, W_C);
    apply_stimulus(36);
    clear_expect();
    expect_frame(0, W_C, BT);
    for (int c = 0; c < 36; c++) begin
      n_checks++;
      if (cap0[c] !== expv[c]) begin
        n_fail++;
        $display("[TB] FAIL post_reset cycle %0d got %b expected %b", c, cap0[c], expv[c]);
      end
    end
  endtask

  initial begin
    $display("[TB] echo_serializador bench start");
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_overrun();
    test_frame_end_collision();
    test_bit_ticks_one();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
